// File: rtl/uw_sync_pkg.sv
// uw_sync_pkg: shared types and constants for the
// unique-word acquisition block.
package uw_sync_pkg;

    typedef enum logic [1:0] {
        P_0,
        P_90,
        P_180,
        P_270
    } phase_e;

    localparam logic [31:0] SYNC_WORDS_DEF = 32'h274ED8B1;

    typedef enum logic [2:0] {
        CLEAR,
        ACCUM,
        DRAIN,
        SCAN,
        REPORT
    } state_e;

    function automatic int wgt_width(input int nf, input int sl);
        return $clog2(nf * sl + 1);
    endfunction

endpackage

// File: rtl/uw_corr_bank.sv
// uw_corr_bank: one phase hypothesis. Correlates the window
// against its word and accumulates per-offset weights.
module uw_corr_bank
    import uw_sync_pkg::*;
#(
    parameter int                  BITS_PER_FRAME = 80,
    parameter int                  SYNC_LEN       = 8,
    parameter int                  WGT_W          = 9,
    parameter logic [SYNC_LEN-1:0] WORD           = 8'h27
) (
    input  logic                              clk,
    input  logic                              rst_i,
    input  logic [SYNC_LEN-1:0]               win_i,
    input  logic                              acc_v_i,
    input  logic [$clog2(BITS_PER_FRAME)-1:0] acc_addr_i,
    input  logic                              clr_en_i,
    input  logic [$clog2(BITS_PER_FRAME)-1:0] clr_addr_i,
    output logic [WGT_W-1:0]                  rd_data_o
);

    localparam int AW  = $clog2(BITS_PER_FRAME);
    localparam int PCW = $clog2(SYNC_LEN + 1);

    logic [PCW-1:0]   pc_d;
    logic [PCW-1:0]   pc_q;
    logic             wv_q;
    logic [AW-1:0]    wa_q;
    logic [WGT_W-1:0] sum;
    logic [WGT_W-1:0] unused_doutb;

    // Number of window bits that agree with this bank's word.
    always_comb begin
        pc_d = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            pc_d = pc_d + PCW'(~(win_i[i] ^ WORD[i]));
        end
    end

    // Hold the match count and address until the old weight is read.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wv_q <= 1'b0;
            wa_q <= '0;
            pc_q <= '0;
        end else begin
            wv_q <= acc_v_i;
            if (acc_v_i) begin
                wa_q <= acc_addr_i;
                pc_q <= pc_d;
            end
        end
    end

    assign sum = rd_data_o + WGT_W'(pc_q);

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH(WGT_W),
        .RAM_DEPTH(BITS_PER_FRAME)
    ) u_ram (
        .addra (clr_en_i ? clr_addr_i : acc_addr_i),
        .addrb (wa_q),
        .dina  ('0),
        .dinb  (sum),
        .clka  (clk),
        .clkb  (clk),
        .wea   (clr_en_i),
        .web   (wv_q),
        .ena   (acc_v_i | clr_en_i),
        .enb   (wv_q),
        .douta (rd_data_o),
        .doutb (unused_doutb)
    );

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// True dual-port RAM, read-first on both ports.
// Both ports are clocked from clka; clkb is kept for template compatibility.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         clkb,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic                 unused_clkb;

    assign unused_clkb = clkb;

    // Read old contents, then write, on each enabled port.
    always_ff @(posedge clka) begin
        if (ena) begin
            douta <= mem[addra];
            if (wea) mem[addra] <= dina;
        end
        if (enb) begin
            doutb <= mem[addrb];
            if (web) mem[addrb] <= dinb;
        end
    end

endmodule

// File: rtl/uw_sync_search.sv
// uw_sync_search: unique-word acquisition over a block of
// frames; reports best offset, weight, rotation and lock.
module uw_sync_search
    import uw_sync_pkg::*;
#(
    parameter int                            BITS_PER_FRAME = 80,
    parameter int                            NUM_FRAMES     = 32,
    parameter int                            SYNC_LEN       = 8,
    parameter int                            NUM_ROT        = 4,
    parameter logic [NUM_ROT*SYNC_LEN-1:0]   SYNC_WORDS     = SYNC_WORDS_DEF,
    parameter int                            LOCK_THRESH    = 224
) (
    input  logic                                       clk,
    input  logic                                       rst_in,
    input  logic                                       hard_inp,
    input  logic                                       valid_in,
    output logic                                       ready_rx,
    output logic                                       valid_out,
    output logic [$clog2(BITS_PER_FRAME)-1:0]          bit_offset,
    output logic [wgt_width(NUM_FRAMES, SYNC_LEN)-1:0] max_offset_weight,
    output logic [$clog2(NUM_ROT)-1:0]                 rotation,
    output logic                                       locked
);

    localparam int AW    = $clog2(BITS_PER_FRAME);
    localparam int RW    = $clog2(NUM_ROT);
    localparam int WGT_W = wgt_width(NUM_FRAMES, SYNC_LEN);
    localparam int TOTAL = NUM_FRAMES * BITS_PER_FRAME;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(BITS_PER_FRAME + 2);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NW-1:0]       n_q, n_d;
    logic [AW-1:0]       off_q, off_d;
    logic [SYNC_LEN-1:0] win_q, win_d;
    logic                acc_v_q, acc_v_d;
    logic [AW-1:0]       acc_addr_q, acc_addr_d;
    logic                rd_v_q, rd_v_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [WGT_W-1:0]    best_w_q, best_w_d;
    logic [AW-1:0]       best_off_q, best_off_d;
    logic [RW-1:0]       best_rot_q, best_rot_d;
    logic                vo_q, vo_d;
    logic [AW-1:0]       offs_q, offs_d;
    logic [WGT_W-1:0]    wgt_q, wgt_d;
    logic [RW-1:0]       rot_q, rot_d;
    logic                lock_q, lock_d;
    logic                clr_en;
    logic                take;
    logic [WGT_W-1:0]    rd_data [NUM_ROT];

    assign ready_rx          = (state_q == ACCUM);
    assign take              = valid_in & ready_rx;
    assign valid_out         = vo_q;
    assign bit_offset        = offs_q;
    assign max_offset_weight = wgt_q;
    assign rotation          = rot_q;
    assign locked            = lock_q;

    for (genvar r = 0; r < NUM_ROT; r++) begin : g_bank
        uw_corr_bank #(
            .BITS_PER_FRAME(BITS_PER_FRAME),
            .SYNC_LEN      (SYNC_LEN),
            .WGT_W         (WGT_W),
            .WORD          (SYNC_WORDS[(NUM_ROT-1-r)*SYNC_LEN +: SYNC_LEN])
        ) u_bank (
            .clk       (clk),
            .rst_i     (rst_in),
            .win_i     (win_q),
            .acc_v_i   (acc_v_q),
            .acc_addr_i(acc_addr_q),
            .clr_en_i  (clr_en),
            .clr_addr_i(cnt_q[AW-1:0]),
            .rd_data_o (rd_data[r])
        );
    end

    // Sequencing: clear, accumulate, drain, scan, report.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        off_d      = off_q;
        win_d      = win_q;
        acc_v_d    = 1'b0;
        acc_addr_d = acc_addr_q;
        rd_v_d     = 1'b0;
        rd_addr_d  = cnt_q[AW-1:0];
        vo_d       = 1'b0;
        offs_d     = offs_q;
        wgt_d      = wgt_q;
        rot_d      = rot_q;
        lock_d     = lock_q;
        clr_en     = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
                if (cnt_q == CW'(BITS_PER_FRAME - 1)) begin
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCUM: begin
                if (take) begin
                    win_d = {win_q[SYNC_LEN-2:0], hard_inp};
                    n_d   = n_q + 1'b1;
                    if (n_q >= NW'(SYNC_LEN - 1)) begin
                        acc_v_d    = 1'b1;
                        acc_addr_d = off_q;
                        off_d = (off_q == AW'(BITS_PER_FRAME - 1))
                              ? '0 : off_q + 1'b1;
                    end
                    if (n_q == NW'(TOTAL - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCAN: begin
                clr_en = (cnt_q < CW'(BITS_PER_FRAME));
                rd_v_d = clr_en;
                if (cnt_q == CW'(BITS_PER_FRAME + 1)) begin
                    cnt_d   = '0;
                    state_d = REPORT;
                    vo_d    = 1'b1;
                    offs_d  = best_off_q;
                    wgt_d   = best_w_q;
                    rot_d   = best_rot_q;
                    lock_d  = (best_w_q >= WGT_W'(LOCK_THRESH));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPORT: begin
                n_d     = '0;
                off_d   = '0;
                win_d   = '0;
                state_d = ACCUM;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Running max over the scan; earlier offset/rotation wins ties.
    always_comb begin
        best_w_d   = best_w_q;
        best_off_d = best_off_q;
        best_rot_d = best_rot_q;
        if (state_q == DRAIN) begin
            best_w_d   = '0;
            best_off_d = '0;
            best_rot_d = '0;
        end else if (rd_v_q) begin
            for (int r = 0; r < NUM_ROT; r++) begin
                if (rd_data[r] > best_w_d) begin
                    best_w_d   = rd_data[r];
                    best_off_d = rd_addr_q;
                    best_rot_d = RW'(r);
                end
            end
        end
    end

    // State, counters, pipeline and result registers.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            n_q        <= '0;
            off_q      <= '0;
            win_q      <= '0;
            acc_v_q    <= 1'b0;
            acc_addr_q <= '0;
            rd_v_q     <= 1'b0;
            rd_addr_q  <= '0;
            best_w_q   <= '0;
            best_off_q <= '0;
            best_rot_q <= '0;
            vo_q       <= 1'b0;
            offs_q     <= '0;
            wgt_q      <= '0;
            rot_q      <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            off_q      <= off_d;
            win_q      <= win_d;
            acc_v_q    <= acc_v_d;
            acc_addr_q <= acc_addr_d;
            rd_v_q     <= rd_v_d;
            rd_addr_q  <= rd_addr_d;
            best_w_q   <= best_w_d;
            best_off_q <= best_off_d;
            best_rot_q <= best_rot_d;
            vo_q       <= vo_d;
            offs_q     <= offs_d;
            wgt_q      <= wgt_d;
            rot_q      <= rot_d;
            lock_q     <= lock_d;
        end
    end

endmodule

// File: tb/tb_uw_sync_search.sv
// tb_uw_sync_search: directed blocks with random filler,
// checked against a frame-level correlation model.
module tb_uw_sync_search;

    localparam int BPF   = 80;
    localparam int NF    = 32;
    localparam int SL    = 8;
    localparam int NR    = 4;
    localparam int TOTAL = BPF * NF;
    localparam int P     = 10;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       hard_inp;
    logic       valid_in;
    logic       ready_rx;
    logic       valid_out;
    logic [6:0] bit_offset;
    logic [8:0] max_offset_weight;
    logic [1:0] rotation;
    logic       locked;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          stream [TOTAL];
    int          m_off, m_rot, m_w;
    int          s_off, s_rot, s_w;
    bit          drop;
    logic [31:0] words = 32'h274ED8B1;

    uw_sync_search dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .hard_inp         (hard_inp),
        .valid_in         (valid_in),
        .ready_rx         (ready_rx),
        .valid_out        (valid_out),
        .bit_offset       (bit_offset),
        .max_offset_weight(max_offset_weight),
        .rotation         (rotation),
        .locked           (locked)
    );

    always #(P/2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: random filler with word at offset; 1: zeros; 2: random
    task automatic gen(input int mode, input int off, input logic [7:0] w);
        for (int i = 0; i < TOTAL; i++)
            stream[i] = (mode == 1) ? 1'b0 : 1'($urandom & 1);
        if (mode == 0)
            for (int f = 0; f < NF; f++)
                for (int k = 0; k < SL; k++)
                    stream[f*BPF + off + k] = w[SL-1-k];
    endtask

    // Correlate every full in-block window with every word.
    task automatic model();
        logic [7:0] wd;
        int         wgt;
        m_w = -1; m_off = 0; m_rot = 0;
        for (int o = 0; o < BPF; o++)
            for (int r = 0; r < NR; r++) begin
                wd  = words[(NR-1-r)*SL +: SL];
                wgt = 0;
                for (int f = 0; f < NF; f++)
                    if (f*BPF + o + SL <= TOTAL)
                        for (int k = 0; k < SL; k++)
                            if (stream[f*BPF + o + k] == wd[SL-1-k]) wgt++;
                if (wgt > m_w) begin
                    m_w = wgt; m_off = o; m_rot = r;
                end
            end
    endtask

    task automatic send(input bit gaps, input int lim);
        int idx = 0;
        int guard = 0;
        bit started = 0;
        bit rdy, v;
        drop = 0;
        while (idx < lim && guard < 4*TOTAL + 500) begin
            @(negedge clk);
            rdy = ready_rx;
            if (started && !rdy) drop = 1;
            v = gaps ? 1'($urandom & 1) : 1'b1;
            valid_in = v;
            hard_inp = stream[idx];
            @(posedge clk);
            if (v && rdy) begin
                idx++;
                started = 1;
            end
            guard++;
        end
        #1 valid_in = 1'b0;
        chk("accepted_bits", idx, lim);
    endtask

    task automatic collect();
        int cyc = 0;
        bit got = 0;
        bit rdy_bad = 0;
        while (cyc < BPF + 40) begin
            @(negedge clk);
            cyc++;
            if (ready_rx) rdy_bad = 1;
            if (valid_out) begin
                got = 1;
                break;
            end
        end
        chk("vo_seen", got, 1);
        chk("latency", cyc - 1, BPF + 4);
        chk("rdy_low", rdy_bad, 0);
        chk("offset", bit_offset, m_off);
        chk("rotation", rotation, m_rot);
        chk("weight", max_offset_weight, m_w);
        chk("locked", locked, (m_w >= 224));
        @(negedge clk);
        chk("vo_pulse", valid_out, 0);
        chk("rdy_back", ready_rx, 1);
        chk("offset_hold", bit_offset, m_off);
    endtask

    task automatic clear_len();
        int k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1 k++;
            if (ready_rx) break;
        end
        chk("clear_len", k, BPF);
    endtask

    initial begin
        int zmax;
        rst_in   = 1'b1;
        valid_in = 1'b0;
        hard_inp = 1'b0;
        void'($urandom(32'd20240611));
        #(2*P + 2);
        chk("rst_ready", ready_rx, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_offset", bit_offset, 0);
        chk("rst_weight", max_offset_weight, 0);
        chk("rst_rot", rotation, 0);
        chk("rst_lock", locked, 0);
        @(negedge clk);
        rst_in = 1'b0;
        clear_len();

        gen(0, 37, 8'h27);
        model();
        send(0, TOTAL);
        collect();
        chk("a_off37", bit_offset, 37);
        chk("a_rot0", rotation, 0);
        chk("a_w256", max_offset_weight, 256);
        chk("a_lock", locked, 1);
        s_off = bit_offset;
        s_rot = rotation;
        s_w   = max_offset_weight;

        send(1, TOTAL);
        chk("gap_rdy_hold", drop, 0);
        collect();
        chk("gap_same_off", bit_offset, s_off);
        chk("gap_same_rot", rotation, s_rot);
        chk("gap_same_w", max_offset_weight, s_w);

        gen(0, 5, 8'hD8);
        model();
        send(0, TOTAL);
        collect();
        chk("c_off5", bit_offset, 5);
        chk("c_rot2", rotation, 2);
        chk("c_w256", max_offset_weight, 256);

        gen(1, 0, 8'h00);
        model();
        send(0, TOTAL);
        collect();
        zmax = 0;
        for (int r = 0; r < NR; r++)
            if (SL - $countones(words[(NR-1-r)*SL +: SL]) > zmax)
                zmax = SL - $countones(words[(NR-1-r)*SL +: SL]);
        chk("z_off0", bit_offset, 0);
        chk("z_rot0", rotation, 0);
        chk("z_weight", max_offset_weight, NF * zmax);

        gen(2, 0, 8'h00);
        model();
        send(0, TOTAL);
        collect();
        chk("rnd_unlocked", locked, 0);
        chk("rnd_below", (max_offset_weight < 224), 1);

        gen(0, 37, 8'h27);
        model();
        send(0, TOTAL);
        collect();
        gen(0, 60, 8'h27);
        model();
        send(0, TOTAL);
        collect();
        chk("b2b_off60", bit_offset, 60);
        chk("b2b_w256", max_offset_weight, 256);

        gen(0, 37, 8'h27);
        send(0, 700);
        rst_in = 1'b1;
        #1;
        chk("arst_offset", bit_offset, 0);
        chk("arst_weight", max_offset_weight, 0);
        chk("arst_lock", locked, 0);
        chk("arst_ready", ready_rx, 0);
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        clear_len();
        gen(0, 12, 8'h27);
        model();
        send(0, TOTAL);
        collect();
        chk("r_off12", bit_offset, 12);
        chk("r_w256", max_offset_weight, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
